// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle valid/framing strobes.
// Optional 8E1 framing with parity_err output when UART_RX_PARITY_EN is defined.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned CNT_W        = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic [7:0]       data_r, data_nxt_s;
    logic             armed_r, armed_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             ferr_r, ferr_nxt_s;
    logic             busy_r;
    logic             sync1_r, sync2_r;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_r, par_nxt_s;
    logic             perr_r, perr_nxt_s;
`endif

    assign rx_s = sync2_r;

    // Two-flop synchronizer for the asynchronous serial line, idle-high on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= RxD;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, datapath and strobe logic; IDLE only arms after seeing the line high
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_r;
        armed_nxt_s = armed_r;
        valid_nxt_s = 1'b0;
        ferr_nxt_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt_s   = par_r;
        perr_nxt_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (rx_s) begin
                    armed_nxt_s = 1'b1;
                end else if (armed_r) begin
                    armed_nxt_s = 1'b0;
                    state_nxt_s = START;
                end else begin
                    armed_nxt_s = 1'b0;
                end
            end
            START: begin
                if (cnt_r == HALF_CNT) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    idx_nxt_s = 3'd0;
                    if (!rx_s) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == FULL_CNT) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = {rx_s, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == FULL_CNT) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    par_nxt_s   = rx_s;
                    state_nxt_s = STOP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_r == FULL_CNT) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = IDLE;
                    if (!rx_s) begin
                        ferr_nxt_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad(shift_r, par_r)) begin
                        perr_nxt_s = 1'b1;
`endif
                    end else begin
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = shift_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                armed_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            armed_r <= 1'b0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r   <= 1'b0;
            perr_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            data_r  <= data_nxt_s;
            armed_r <= armed_nxt_s;
            valid_r <= valid_nxt_s;
            ferr_r  <= ferr_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
`ifdef UART_RX_PARITY_EN
            par_r   <= par_nxt_s;
            perr_r  <= perr_nxt_s;
`endif
        end
    end

    assign data_out    = data_r;
    assign rx_valid    = valid_r;
    assign framing_err = ferr_r;
    assign busy        = busy_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_r;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // stop-bit sample latency from the first clock edge that sees the start bit
    localparam int LAT = 2 + (CPB - 1) / 2 + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       framing_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int both_cnt = 0;
    int long_cnt = 0;
    int busy_low_mid = 0;
    logic prev_pulse = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(14)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RxD(RxD),
        .data_out(data_out),
        .rx_valid(rx_valid),
        .framing_err(framing_err),
        .busy(busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor: counts strobes, overlaps and multi-cycle strobes
    always @(negedge clk) begin
        logic any_pulse;
        any_pulse = rx_valid | framing_err;
`ifdef UART_RX_PARITY_EN
        any_pulse = any_pulse | parity_err;
        if (parity_err === 1'b1) perr_cnt++;
        if (parity_err === 1'b1 && (rx_valid === 1'b1 || framing_err === 1'b1)) both_cnt++;
`endif
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (framing_err === 1'b1) ferr_cnt++;
        if (rx_valid === 1'b1 && framing_err === 1'b1) both_cnt++;
        if (any_pulse === 1'b1 && prev_pulse === 1'b1) long_cnt++;
        prev_pulse = any_pulse;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            RxD = frame[i];
            repeat (CPB / 2) @(negedge clk);
            if (busy !== 1'b1) busy_low_mid++;
            repeat (CPB / 2 - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [10:0] frame;
`ifdef UART_RX_PARITY_EN
        frame = {stop, ^d, d, 1'b0};
`else
        frame = {1'b0, stop, d, 1'b0};
`endif
        send_bits(frame, NBITS);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
        total++;
        if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        total++;
        if (framing_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", framing_err); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef UART_RX_PARITY_EN
        total++;
        if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", parity_err); end
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        int v0, f0, lat;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        busy_low_mid = 0;
        send_frame(8'hA5, 1'b1);
        lat = valid_cyc - (start_cyc + 1);
        total++;
        if (data_out !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", data_out); end
        total++;
        if (valid_cnt - v0 != 1) begin bad++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
        total++;
        if (lat < LAT - 1 || lat > LAT + 1) begin bad++; $display("FAIL a5_latency: got %0d want %0d+-1", lat, LAT); end
        total++;
        if (ferr_cnt != f0) begin bad++; $display("FAIL a5_no_ferr: got %0d want %0d", ferr_cnt, f0); end
        total++;
        if (busy_low_mid != 0) begin bad++; $display("FAIL a5_busy_mid: low at %0d bit centres want 0", busy_low_mid); end
        wait_idle();
    endtask

    task automatic test_glitch();
        int v0, f0;
        logic saw_busy;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        saw_busy = 1'b0;
        @(negedge clk);
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        total++;
        if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_pulse: got %b want 1", saw_busy); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: busy=%b want 0", busy); end
        total++;
        if (valid_cnt != v0 || ferr_cnt != f0) begin
            bad++;
            $display("FAIL glitch_no_strobe: valid+%0d ferr+%0d want 0 0", valid_cnt - v0, ferr_cnt - f0);
        end
        total++;
        if (data_out !== 8'hA5) begin bad++; $display("FAIL glitch_data: got %h want a5", data_out); end
    endtask

    task automatic test_framing();
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        @(negedge clk);
        RxD = 1'b1;
        total++;
        if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        total++;
        if (valid_cnt != v0) begin bad++; $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0); end
        total++;
        if (data_out !== 8'hA5) begin bad++; $display("FAIL ferr_data_kept: got %h want a5", data_out); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", data_out); end
        send_frame(8'hFF, 1'b1);
        total++;
        if (data_out !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", data_out); end
        total++;
        if (valid_cnt - v0 != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        logic [10:0] frame;
        frame = {2'b01, 8'h55, 1'b0};
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            RxD = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        RxD = frame[5];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", data_out); end
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (valid_cnt != v0 || ferr_cnt != f0) begin
            bad++;
            $display("FAIL midrst_no_strobe: valid+%0d ferr+%0d want 0 0", valid_cnt - v0, ferr_cnt - f0);
        end
        send_frame(8'h81, 1'b1);
        total++;
        if (data_out !== 8'h81) begin bad++; $display("FAIL midrst_next_data: got %h want 81", data_out); end
        total++;
        if (valid_cnt - v0 != 1) begin bad++; $display("FAIL midrst_next_count: got %0d want 1", valid_cnt - v0); end
        wait_idle();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        v0 = valid_cnt;
        p0 = perr_cnt;
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        total++;
        if (data_out !== 8'h07) begin bad++; $display("FAIL par_good_data: got %h want 07", data_out); end
        total++;
        if (valid_cnt - v0 != 1 || perr_cnt != p0) begin
            bad++;
            $display("FAIL par_good_strobes: valid+%0d perr+%0d want 1 0", valid_cnt - v0, perr_cnt - p0);
        end
        wait_idle();
        v0 = valid_cnt;
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        total++;
        if (perr_cnt - p0 != 1 || valid_cnt != v0) begin
            bad++;
            $display("FAIL par_bad_strobes: perr+%0d valid+%0d want 1 0", perr_cnt - p0, valid_cnt - v0);
        end
        wait_idle();
    endtask
`endif

    task automatic test_exclusivity();
        total++;
        if (both_cnt != 0) begin bad++; $display("FAIL overlap_strobes: got %0d want 0", both_cnt); end
        total++;
        if (long_cnt != 0) begin bad++; $display("FAIL long_strobes: got %0d want 0", long_cnt); end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_exclusivity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receive stage that consumes the serial TxD line produced by the transmitter.
- Recovers one byte per frame and presents it on a parallel bus with a one-cycle valid strobe. Reports framing errors.
- Used for loopback verification of the transmitter, and as the receive half of the UART top.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per bit period (100 MHz / 9600 baud); minimum 4.
- CNT_W, 14, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RxD  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse: data_out has just been updated.
- framing_err  output  1  one-cycle pulse: the stop bit was sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All flops clear on rst_n low, with no clock required.
- Reset values: data_out = 8'h00, rx_valid = 0, framing_err = 0, busy = 0. FSM = IDLE, counters = 0. Synchronizer flops reset to 1 (line idle).
- Input synchronization: RxD passes through a 2-flop synchronizer; only the synchronized signal rx_s is used. This adds 2 cycles of latency.
- IDLE:
  - busy = 0.
  - When rx_s == 0: clear the bit counter and go to START.
- START:
  - Count to (CLKS_PER_BIT-1)/2, integer division (mid-bit).
  - If rx_s == 0 at that point: clear the counter and go to DATA.
  - Otherwise the start is a glitch: return to IDLE with no strobe.
- DATA:
  - Every CLKS_PER_BIT cycles after the mid-start sample, sample rx_s into a shift register, LSB first.
  - A 3-bit index counts bits 0..7. After bit 7, clear the counter and go to STOP.
- STOP: sample rx_s after CLKS_PER_BIT cycles.
  - If rx_s == 1: load data_out from the shift register and pulse rx_valid for exactly 1 cycle.
  - If rx_s == 0: pulse framing_err for 1 cycle; data_out is unchanged.
  - In both cases, go to IDLE in the same cycle.
- Back-to-back frames: returning to IDLE at the stop-bit mid-point leaves half a bit of margin, so a start bit immediately after the stop bit is detected.
- Latency: rx_valid rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles (±1) after the RxD falling edge.
- Pulse exclusivity: rx_valid and framing_err are never high together. Neither is ever high for more than one cycle.
- Break condition: RxD held low.
  - The first frame reports framing_err.
  - The FSM then re-enters START only after rx_s has returned high (IDLE requires a 1→0 transition).
  - Implementation: IDLE arms only after observing rx_s == 1.
- Reset mid-frame: the FSM aborts immediately and no strobe is produced. After release, the block resynchronizes on the next falling edge seen after the line has been high.
- Counter rule: the counter is CNT_W bits and never wraps within a bit period.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1: one even-parity bit follows bit 7. A PARITY state samples it after CLKS_PER_BIT cycles.
  - An extra output, parity_err (1 bit, resets to 0), pulses for 1 cycle at the stop sample when the XOR of the 8 data bits and the parity bit is 1. In that case data_out is not updated and rx_valid does not pulse.
  - Framing error takes precedence: if the stop bit is low, only framing_err pulses.
- Undefined: the frame is 8N1, the PARITY state does not exist, and the parity_err port is absent.

Test Plan (CLKS_PER_BIT = 16 for simulation):
- Frame 0xA5 with a valid stop bit -> data_out = 8'hA5; a single rx_valid pulse 2 + 7 + 144 cycles (±1) after the start edge; busy is high throughout and then drops to 0.
- RxD low for 4 cycles, then high -> busy pulses, returns to IDLE, no rx_valid, no framing_err, data_out unchanged.
- Frame 0x3C with the stop bit driven low -> framing_err pulses once, rx_valid stays 0, data_out keeps its previous value (8'hA5).
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data_out = 8'h00 then 8'hFF.
- Assert rst_n low during bit 4 of frame 0x55, release, then send 0x81 -> no strobe for the aborted frame; data_out = 8'h81 with one rx_valid pulse.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> rx_valid, data_out = 8'h07; send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.
